// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between writeback and MDU results
// Writeback wins every slot it uses; MDU results queue in a small FIFO and drain into idle slots.
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       mdu_valid,
    output logic                       mdu_ready,
    input  logic [ADDR_W-1:0]          mdu_addr,
    input  logic [DATA_W-1:0]          mdu_data,
    output logic [ADDR_W-1:0]          dest_address,
    output logic [DATA_W-1:0]          writeBack_data,
    output logic                       reg_write,
    input  logic [ADDR_W-1:0]          rs_query,
    input  logic [ADDR_W-1:0]          rt_query,
    output logic                       rs_pending,
    output logic                       rt_pending,
    output logic                       wb_stall,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] AGE_LIMIT  = AW'(STARVE_LIMIT);

    typedef enum logic {
        SLOT_EMPTY  = 1'b0,
        SLOT_QUEUED = 1'b1
    } slot_state_t;

    slot_state_t         r_slot      [DEPTH];
    logic [ADDR_W-1:0]   r_fifo_addr [DEPTH];
    logic [DATA_W-1:0]   r_fifo_data [DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [AW-1:0]       r_age;
    logic                r_reg_write;
    logic [ADDR_W-1:0]   r_dest;
    logic [DATA_W-1:0]   r_data;

    logic                w_wb_issue;
    logic                w_fifo_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_rs_hit;
    logic                w_rt_hit;

    assign w_wb_issue   = wb_valid && (wb_addr != '0);
    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = !w_wb_issue && !w_fifo_empty;
    // Address-0 MDU results complete the handshake but are never stored.
    assign w_push       = mdu_valid && mdu_ready && (mdu_addr != '0);

    assign mdu_ready      = !rst && (r_count < FULL_COUNT);
    assign wb_stall       = (r_count == FULL_COUNT) || (r_age == AGE_LIMIT);
    assign fifo_count     = r_count;
    assign reg_write      = r_reg_write;
    assign dest_address   = r_dest;
    assign writeBack_data = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i]      <= SLOT_EMPTY;
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_slot[r_rd_ptr] <= SLOT_EMPTY;
                r_rd_ptr         <= r_rd_ptr + 1'b1;
            end
            // Push and pop never target the same slot: that needs empty or full.
            if (w_push) begin
                r_slot[r_wr_ptr]      <= SLOT_QUEUED;
                r_fifo_addr[r_wr_ptr] <= mdu_addr;
                r_fifo_data[r_wr_ptr] <= mdu_data;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age <= '0;
        end else if (w_fifo_empty || w_pop) begin
            r_age <= '0;
        end else if (w_wb_issue && (r_age != AGE_LIMIT)) begin
            r_age <= r_age + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write <= 1'b0;
            r_dest      <= '0;
            r_data      <= '0;
        end else if (w_wb_issue) begin
            r_reg_write <= 1'b1;
            r_dest      <= wb_addr;
            r_data      <= wb_data;
        end else if (w_pop) begin
            r_reg_write <= 1'b1;
            r_dest      <= r_fifo_addr[r_rd_ptr];
            r_data      <= r_fifo_data[r_rd_ptr];
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    // The output stage counts as pending: the register file commits mid-cycle.
    always_comb begin
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_slot[i] == SLOT_QUEUED) begin
                if (r_fifo_addr[i] == rs_query) w_rs_hit = 1'b1;
                if (r_fifo_addr[i] == rt_query) w_rt_hit = 1'b1;
            end
        end
        if (r_reg_write && (r_dest == rs_query)) w_rs_hit = 1'b1;
        if (r_reg_write && (r_dest == rt_query)) w_rt_hit = 1'b1;
    end

    assign rs_pending = (rs_query != '0) && w_rs_hit;
    assign rt_pending = (rt_query != '0) && w_rt_hit;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          mdu_valid = 1'b0;
    logic          mdu_ready;
    logic [AW-1:0] mdu_addr = '0;
    logic [DW-1:0] mdu_data = '0;
    logic [AW-1:0] dest_address;
    logic [DW-1:0] writeBack_data;
    logic          reg_write;
    logic [AW-1:0] rs_query = '0;
    logic [AW-1:0] rt_query = '0;
    logic          rs_pending;
    logic          rt_pending;
    logic          wb_stall;
    logic [1:0]    fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .dest_address(dest_address), .writeBack_data(writeBack_data),
        .reg_write(reg_write),
        .rs_query(rs_query), .rt_query(rt_query),
        .rs_pending(rs_pending), .rt_pending(rt_pending),
        .wb_stall(wb_stall), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic          m_rw   = 1'b0;
    logic [AW-1:0] m_dest = '0;
    logic [DW-1:0] m_data = '0;
    int            m_age  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_pending(input logic [AW-1:0] q);
        if (q == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].a == q) return 1'b1;
        return m_rw && (m_dest == q);
    endfunction

    // Queue-level model: writeback first, else oldest queued MDU result.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_rw = 1'b0; m_dest = '0; m_data = '0; m_age = 0;
            end else begin
                int  sz;
                bit  ready, wbi, popped;
                sz     = mq.size();
                ready  = (sz < DEPTH);
                wbi    = wb_valid && (wb_addr != 0);
                popped = 1'b0;
                if (wbi) begin
                    m_rw = 1'b1; m_dest = wb_addr; m_data = wb_data;
                end else if (sz > 0) begin
                    ent_t e;
                    e = mq.pop_front();
                    m_rw = 1'b1; m_dest = e.a; m_data = e.d;
                    popped = 1'b1;
                end else begin
                    m_rw = 1'b0;
                end
                if (sz == 0 || popped) m_age = 0;
                else if (wbi && m_age < LIMIT) m_age = m_age + 1;
                if (mdu_valid && ready && mdu_addr != 0) mq.push_back('{a: mdu_addr, d: mdu_data});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("reg_write",   64'(reg_write),      64'(m_rw));
            chk("dest_address",64'(dest_address),   64'(m_dest));
            chk("wb_data_out", 64'(writeBack_data), 64'(m_data));
            chk("fifo_count",  64'(fifo_count),     64'(mq.size()));
            chk("mdu_ready",   64'(mdu_ready),      64'(!rst && mq.size() < DEPTH));
            chk("wb_stall",    64'(wb_stall),       64'(mq.size() == DEPTH || m_age == LIMIT));
            chk("rs_pending",  64'(rs_pending),     64'(m_pending(rs_query)));
            chk("rt_pending",  64'(rt_pending),     64'(m_pending(rt_query)));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_valid = v; wb_addr = a; wb_data = d;
    endtask

    task automatic set_mdu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mdu_valid = v; mdu_addr = a; mdu_data = d;
    endtask

    initial begin
        #2;
        chk("rst_reg_write", 64'(reg_write), 0);
        chk("rst_ready",     64'(mdu_ready), 0);
        chk("rst_count",     64'(fifo_count), 0);
        chk("rst_stall",     64'(wb_stall), 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(mdu_ready), 1);

        // isolated writeback
        set_wb(1, 7, 32'h1234);
        tick();
        chk("wb_rw",   64'(reg_write), 1);
        chk("wb_dest", 64'(dest_address), 7);
        chk("wb_data", 64'(writeBack_data), 32'h1234);
        set_wb(0, 0, 0);
        tick();
        chk("wb_idle_rw", 64'(reg_write), 0);

        // MDU drain under writeback conflict
        set_wb(1, 10, 32'h1);
        set_mdu(1, 3, 32'hAA);
        tick();
        set_mdu(1, 4, 32'hBB);
        tick();
        chk("full_count", 64'(fifo_count), 2);
        chk("full_ready", 64'(mdu_ready), 0);
        chk("full_stall", 64'(wb_stall), 1);
        set_mdu(0, 0, 0);
        set_wb(0, 0, 0);
        tick();
        chk("drain1_dest", 64'(dest_address), 3);
        chk("drain1_data", 64'(writeBack_data), 32'hAA);
        tick();
        chk("drain2_dest", 64'(dest_address), 4);
        chk("drain2_data", 64'(writeBack_data), 32'hBB);
        chk("drain2_count", 64'(fifo_count), 0);
        tick();
        chk("drain_idle", 64'(reg_write), 0);

        // starvation
        set_wb(1, 5, 32'h55);
        set_mdu(1, 6, 32'h66);
        tick();
        set_mdu(0, 0, 0);
        chk("starve_0", 64'(wb_stall), 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("starve_%0d", k), 64'(wb_stall), (k == 4) ? 1 : 0);
        end
        set_wb(0, 0, 0);
        tick();
        chk("starve_pop_dest", 64'(dest_address), 6);
        chk("starve_cleared",  64'(wb_stall), 0);

        // zero-register filtering
        set_wb(1, 5, 32'h55);
        set_mdu(1, 8, 32'h88);
        tick();
        set_mdu(0, 0, 0);
        set_wb(1, 0, 32'hDEAD);
        tick();
        chk("wb0_dest", 64'(dest_address), 8);
        chk("wb0_data", 64'(writeBack_data), 32'h88);
        set_wb(0, 0, 0);
        set_mdu(1, 0, 32'h77);
        tick();
        chk("mdu0_count", 64'(fifo_count), 0);
        chk("mdu0_rw",    64'(reg_write), 0);
        set_mdu(0, 0, 0);

        // pending lookup
        set_wb(1, 5, 32'h55);
        set_mdu(1, 9, 32'h99);
        rs_query = 9; rt_query = 0;
        tick();
        set_mdu(0, 0, 0);
        chk("pend_rs_q", 64'(rs_pending), 1);
        chk("pend_rt_q", 64'(rt_pending), 0);
        set_wb(0, 0, 0);
        tick();
        chk("pend_rs_issue", 64'(rs_pending), 1);
        tick();
        chk("pend_rs_done", 64'(rs_pending), 0);

        // reset mid-operation
        set_wb(1, 5, 32'h55);
        set_mdu(1, 11, 32'h1);
        tick();
        set_mdu(1, 12, 32'h2);
        tick();
        set_mdu(0, 0, 0);
        set_wb(0, 0, 0);
        rs_query = 11;
        chk("pre_rst_count", 64'(fifo_count), 2);
        rst = 1'b1;
        #1;
        chk("arst_rw",    64'(reg_write), 0);
        chk("arst_dest",  64'(dest_address), 0);
        chk("arst_data",  64'(writeBack_data), 0);
        chk("arst_count", 64'(fifo_count), 0);
        chk("arst_ready", 64'(mdu_ready), 0);
        chk("arst_rs",    64'(rs_pending), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rel_ready", 64'(mdu_ready), 1);
        tick();
        chk("rel_rw",    64'(reg_write), 0);
        chk("rel_count", 64'(fifo_count), 0);

        // mixed directed vectors exercising pointer wrap
        for (int i = 0; i < 16; i++) begin
            set_wb((i % 3) == 0, AW'(i % 4), DW'(32'h100 + i));
            set_mdu(1'b1, (i == 5) ? AW'(0) : AW'(i + 1), DW'(32'h200 + i));
            rt_query = AW'(i + 1);
            tick();
        end
        set_wb(0, 0, 0);
        set_mdu(0, 0, 0);
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the register file between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). Writeback has fixed priority and is never back-pressured. MDU results wait in a small FIFO and drain into idle write slots. The block also reports pending writes against the decode-stage source addresses so hazard logic can stall, and raises a stall request when the FIFO is full or its head has starved.

## Interface
Parameters:
- DATA_W, 32, data width of a register write
- ADDR_W, 5, register address width
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles the FIFO head may wait before a stall is forced (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  writeback stage has a result this cycle
- wb_addr  in  ADDR_W  writeback destination register
- wb_data  in  DATA_W  writeback data
- mdu_valid  in  1  MDU offers a result
- mdu_ready  out  1  FIFO can accept; transfer when mdu_valid && mdu_ready
- mdu_addr  in  ADDR_W  MDU destination register
- mdu_data  in  DATA_W  MDU data
- dest_address  out  ADDR_W  register-file write address (registered)
- writeBack_data  out  DATA_W  register-file write data (registered)
- reg_write  out  1  register-file write enable (registered)
- rs_query, rt_query  in  ADDR_W  decode-stage source addresses
- rs_pending, rt_pending  out  1  a write to that address is queued or in the output stage
- wb_stall  out  1  request that the pipeline insert one writeback bubble
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Output stage selection, evaluated each rising edge:
  - wb_valid && wb_addr≠0: issue the writeback. reg_write=1, dest_address=wb_addr, writeBack_data=wb_data.
  - Otherwise, FIFO non-empty: pop the head and issue it, with reg_write=1.
  - Otherwise: reg_write=0. dest_address and writeBack_data hold their values.
- Writeback with wb_addr=0 is discarded and leaves the slot free. The FIFO may pop in that cycle.
- MDU results with mdu_addr=0 are accepted by the handshake but not pushed.
- mdu_ready = !rst && fifo_count<DEPTH. It depends only on the registered count: a full FIFO does not accept, even in a cycle where it pops.
- A push and a pop in the same cycle are allowed; fifo_count stays unchanged.
- FIFO pointers are DEPTH-modulo and wrap naturally.
- Order: MDU results drain strictly in acceptance order.
- Starvation counter age:
  - Cleared on reset, on every pop, and whenever the FIFO is empty.
  - Otherwise increments each cycle a queued head is blocked by writeback, saturating at STARVE_LIMIT.
- wb_stall = (fifo_count==DEPTH) || (age==STARVE_LIMIT). It is combinational from registered state.
- The pipeline honours wb_stall by presenting wb_valid=0 the next cycle. The arbiter does not rely on this for correctness: an ignored stall only delays the drain.
- Pending lookup (combinational):
  - rs_pending=1 when rs_query≠0 and it matches any valid FIFO entry address, or matches dest_address while reg_write=1.
  - rt_pending is the same for rt_query.
  - The output stage is included because the register file commits on the falling edge, so a same-cycle read returns the old value.
- States of each FIFO slot: EMPTY, QUEUED. There is no other FSM. The output stage is a single registered slot.

## Timing
- Reset (asynchronous, immediate):
  - reg_write=0, dest_address=0, writeBack_data=0.
  - fifo_count=0, age=0, pointers=0.
  - mdu_ready=0, wb_stall=0, rs_pending=0, rt_pending=0.
- Reset asserted mid-drain drops all queued entries. No write is issued after reset releases.
- mdu_ready rises combinationally once rst deasserts.
- Latency, writeback: wb_valid sampled at edge N drives reg_write at N+1. The register file commits at the falling edge inside cycle N+1.
- Latency, MDU into an empty FIFO with no writeback competition: accepted at edge N, issued at N+1, visible at N+2. Push at N; pop and issue at N+1.
- Back-to-back issues are allowed every cycle. reg_write may stay high indefinitely.
- The outputs are registered and stable across the falling edge the register file samples on.

## Test plan
- Isolated writeback: wb_valid=1, wb_addr=7, wb_data=0x1234 at edge 1 → reg_write=1, dest_address=7, writeBack_data=0x1234 after edge 1; reg_write=0 after edge 2 with no further input.
- MDU drain plus conflict: MDU pushes addr 3/0xAA then addr 4/0xBB while wb_valid=1 every cycle. Required:
  - fifo_count reaches 2, mdu_ready=0, wb_stall=1.
  - After wb_valid drops: writes issue as 3/0xAA then 4/0xBB on consecutive cycles.
  - fifo_count returns to 0.
- Starvation: one queued MDU entry with wb_valid held high (addr≠0) → wb_stall asserts exactly 4 cycles after the push. It clears the cycle after the entry pops.
- Zero-register filtering: writeback addr 0 with a queued MDU entry → the MDU entry issues that cycle. MDU addr 0 accepted → fifo_count unchanged, no write.
- Pending lookup: queue addr 9 and set rs_query=9, rt_query=0 → rs_pending=1, rt_pending=0. rs_pending stays 1 through the issue cycle and drops the cycle after.
- Reset mid-operation: assert rst with 2 entries queued and reg_write=1. Required:
  - All outputs go to their reset values immediately, without a clock edge.
  - After release: fifo_count=0, mdu_ready=1, no spurious write.
